// File: rtl/j1_uart_tx_io.sv
`timescale 1ns/1ps
// UART transmitter responding on the j1 I/O bus: DATA push port, STATUS read port,
// small byte FIFO and an 8N1 serialiser driving the idle-high line.
module j1_uart_tx_io #(
    parameter logic [15:0] BASE_ADDR = 16'h1000,
    parameter int          CLK_DIV   = 434,
    parameter int          FIFO_AW   = 2
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_rdata_o,
    output logic        uart_tx_o,
    output logic        tx_busy_o
);
    localparam int                DEPTH     = 2 ** FIFO_AW;
    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [15:0]       STAT_ADDR = BASE_ADDR + 16'd1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]         r_mem [0:DEPTH-1];
    logic [FIFO_AW:0]   r_wptr;
    logic [FIFO_AW:0]   r_rptr;
    logic               r_ovf;
    logic [1:0]         r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic w_empty;
    logic w_full;
    logic w_wr_data;
    logic w_stat_rd;
    logic w_bit_end;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;
    logic w_unused;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                       (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_wr_data = io_wr && (io_addr == BASE_ADDR);
    assign w_stat_rd = io_rd && (io_addr == STAT_ADDR);
    assign w_bit_end = (r_baud == BAUD_LAST);

    // The serialiser takes the head byte when idle or at the end of a stop bit.
    assign w_pop     = !w_empty && ((r_state == S_IDLE) ||
                                    ((r_state == S_STOP) && w_bit_end));
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_push    = w_wr_data && (!w_full || w_pop);
    assign w_ovf_set = w_wr_data && w_full && !w_pop;
    assign w_unused  = ^io_dout[15:8];

    always_ff @(posedge sys_clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= io_dout[7:0];
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // A new overflow wins over the clear from a simultaneous STATUS read.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_stat_rd) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr[FIFO_AW-1:0]];
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[r_bit_idx + 3'd1];
                        end
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rptr[FIFO_AW-1:0]];
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        io_rdata_o = 16'h0000;
        if (w_stat_rd) begin
            io_rdata_o = {12'b0, r_ovf, w_full, w_empty, (r_state != S_IDLE)};
        end
    end

    assign uart_tx_o = r_tx;
    assign tx_busy_o = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_j1_uart_tx_io.sv
`timescale 1ns/1ps
// Bench for j1_uart_tx_io: expected frames and STATUS read values are queued by the
// driver and consumed by independent line and bus monitors.
module tb_j1_uart_tx_io;
    localparam int          CLK_DIV = 4;
    localparam int          FRAME   = 10 * CLK_DIV;
    localparam logic [15:0] DATA_A  = 16'h1000;
    localparam logic [15:0] STAT_A  = 16'h1001;

    logic        clk     = 1'b0;
    logic        srst    = 1'b1;
    logic        io_rd   = 1'b0;
    logic        io_wr   = 1'b0;
    logic [15:0] io_addr = 16'h0000;
    logic [15:0] io_dout = 16'h0000;
    logic [15:0] io_rdata;
    logic        tx;
    logic        busy;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    frame_t      exp_q[$];
    logic [15:0] rd_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    j1_uart_tx_io #(
        .BASE_ADDR(DATA_A),
        .CLK_DIV  (CLK_DIV),
        .FIFO_AW  (2)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (srst),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_rdata_o(io_rdata),
        .uart_tx_o (tx),
        .tx_busy_o (busy)
    );

    always #1 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] dout, input logic [15:0] exp_rdata);
        io_rd   = rd;
        io_wr   = wr;
        io_addr = addr;
        io_dout = dout;
        rd_q.push_back(exp_rdata);
        @(negedge clk);
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        io_addr = 16'h0000;
        io_dout = 16'h0000;
    endtask

    // st < 0: byte is not expected on the line (it will be abandoned by reset)
    task automatic send(input logic [7:0] b, input int st);
        if (st >= 0) exp_q.push_back('{data: b, start: st});
        bus(1'b0, 1'b1, DATA_A, {8'hEE, b}, 16'h0000);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frames_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_negs(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (srst) ab = 1'b1;
        end
    endtask

    // Line monitor: finds a start bit, samples mid-bit, compares against the queue.
    initial begin : uart_mon
        frame_t     f;
        logic [7:0] d;
        logic       sb;
        logic       pb;
        int         st;
        bit         ab;
        forever begin
            @(negedge clk);
            if (!srst && tx === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                d  = 8'h00;
                wait_negs(CLK_DIV / 2, ab);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    wait_negs(CLK_DIV, ab);
                    d[i] = tx;
                end
                wait_negs(CLK_DIV, ab);
                pb = tx;
                if (!ab) begin
                    $display("frame 0x%02h start cycle %0d", d, st);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        f = exp_q.pop_front();
                        chk("frame_data", int'(d), int'(f.data));
                        chk("frame_start_cycle", st, f.start);
                        chk("frame_start_stop_bits", int'({sb, pb}), 1);
                    end
                    wait_negs(1, ab);
                end
            end
        end
    end

    // Bus monitor: every bus cycle the driver issued has a queued read-data value.
    initial begin : rd_mon
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #0.5;
            if (io_rd || io_wr) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_bus_op", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    $display("bus rd=%0b wr=%0b addr=0x%04h rdata=0x%04h", io_rd, io_wr, io_addr, io_rdata);
                    chk("io_rdata", int'(io_rdata), int'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int   t0;
        logic low_seen;

        srst = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        srst = 1'b0;
        repeat (3) @(negedge clk);

        // single frame 0xA5, latency and busy duration
        t0 = cyc;
        send(8'hA5, t0 + 2);
        wait_cyc(t0 + 41);
        chk("busy_in_stop", int'(busy), 1);
        @(negedge clk);
        chk("busy_after_frame", int'(busy), 0);
        wait_drain();

        // STATUS decode and non-addressed read data
        bus(1'b1, 1'b0, STAT_A, 16'h0000, 16'h0002);
        bus(1'b1, 1'b0, 16'h1002, 16'h0000, 16'h0000);
        bus(1'b0, 1'b1, STAT_A, 16'h0055, 16'h0000);
        repeat (10) @(negedge clk);
        bus(1'b1, 1'b0, STAT_A, 16'h0000, 16'h0002);

        // four back-to-back frames
        t0 = cyc;
        for (int k = 0; k < 4; k++) send(8'(k + 1), t0 + 2 + k * FRAME);
        wait_drain();

        // overflow: sixth byte dropped, sticky flag cleared by a STATUS read
        t0 = cyc;
        for (int k = 0; k < 6; k++) send(8'(8'h31 + k), (k < 5) ? t0 + 2 + k * FRAME : -1);
        bus(1'b1, 1'b0, STAT_A, 16'h0000, 16'h000D);
        bus(1'b1, 1'b0, STAT_A, 16'h0000, 16'h0005);
        wait_drain();

        // push and pop on the same edge with the FIFO full
        t0 = cyc;
        for (int k = 0; k < 5; k++) send(8'(8'h50 + k), t0 + 2 + k * FRAME);
        wait_cyc(t0 + 41);
        send(8'h55, t0 + 2 + 5 * FRAME);
        bus(1'b1, 1'b0, STAT_A, 16'h0000, 16'h0005);
        wait_drain();

        // reset during data bit 3 with two bytes queued
        t0 = cyc;
        send(8'hC3, -1);
        send(8'h3C, -1);
        send(8'h99, -1);
        wait_cyc(t0 + 19);
        srst = 1'b1;
        @(negedge clk);
        chk("midframe_reset_tx", int'(tx), 1);
        chk("midframe_reset_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        srst = 1'b0;
        low_seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
        end
        chk("line_idle_after_reset", int'(low_seen), 0);
        bus(1'b1, 1'b0, STAT_A, 16'h0000, 16'h0002);
        repeat (5) @(negedge clk);

        chk("scoreboard_empty", exp_q.size() + rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
